// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one combinational alu_8bit between two requesters. In IDLE a single
// pending request is granted directly, and two pending requests are arbitrated
// round-robin. The accepted operands are registered and executed for one cycle
// (EXEC). The result is then held in the response registers (RESP) until the
// consumer takes it. Only one operation is in flight at any time.
//
// Handshake rule, used on every port pair: a transfer happens on a rising
// clock edge where valid and ready are both high. The ready signals are
// combinational from state and valid. A requester must hold a/b/op stable
// while its valid is high and its ready is low.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req0_*, req1_*        valid/ready request channels with operands a, b, op
//   rsp_valid/rsp_ready   response channel carrying rsp_id, rsp_y, rsp_cout
//   busy                  high whenever the FSM is not in IDLE
//   done_cnt              completed response handshakes, wraps modulo 2^CNT_W
//
// alu_8bit opcodes:
//   000 ADD  y = a + b        cout = carry out
//   001 SUB  y = a - b        cout = borrow (a < b)
//   010 AND  cout = 0
//   011 OR   cout = 0
//   100 XOR  cout = 0
//   101 NOT  y = ~a           cout = 0
//   110 SHL  y = a << 1       cout = a[7]
//   111 SHR  y = a >> 1       cout = a[0]
// -----------------------------------------------------------------------------
module alu_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] op,
  output logic [7:0] y,
  output logic       cout
);
  logic [8:0] sum;
  logic [8:0] dif;

  assign sum = {1'b0, a} + {1'b0, b};
  // Two's-complement subtract. Bit 8 is the carry, which is the inverse of
  // the borrow.
  assign dif = {1'b0, a} + {1'b0, ~b} + 9'd1;

  always_comb begin
    y    = 8'h00;
    cout = 1'b0;
    case (op)
      3'b000: begin y = sum[7:0]; cout = sum[8];  end
      3'b001: begin y = dif[7:0]; cout = ~dif[8]; end
      3'b010: y = a & b;
      3'b011: y = a | b;
      3'b100: y = a ^ b;
      3'b101: y = ~a;
      3'b110: begin y = {a[6:0], 1'b0}; cout = a[7]; end
      3'b111: begin y = {1'b0, a[7:1]}; cout = a[0]; end
      default: begin y = 8'h00; cout = 1'b0; end
    endcase
  end
endmodule

module alu_share_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [7:0]       rsp_y,
  output logic             rsp_cout,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic       rr_ptr;     // preferred requester when both are pending
  logic       grant_vld;  // an operation is accepted this cycle
  logic       grant_id;   // which requester is accepted

  logic [7:0] opr_a;
  logic [7:0] opr_b;
  logic [2:0] opr_op;
  logic       opr_id;

  logic [7:0] alu_y;
  logic       alu_cout;

  // Next state and grant decision
  always_comb begin
    state_nxt = state;
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_vld = 1'b1;
          if (req0_valid && req1_valid) grant_id = rr_ptr;
          else                          grant_id = req1_valid;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: state_nxt = S_RESP;
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Gating with rst_n keeps both readies low for the whole reset window,
  // including the time before the first clock edge.
  assign req0_ready = rst_n & grant_vld & ~grant_id;
  assign req1_ready = rst_n & grant_vld &  grant_id;

  assign rsp_valid  = (state == S_RESP);
  assign busy       = (state != S_IDLE);

  // The ALU sees only the registered operands, so requester inputs can move
  // freely once they have been accepted.
  alu_8bit u_alu (
    .a    (opr_a),
    .b    (opr_b),
    .op   (opr_op),
    .y    (alu_y),
    .cout (alu_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rr_ptr   <= 1'b0;
      opr_a    <= 8'h00;
      opr_b    <= 8'h00;
      opr_op   <= 3'b000;
      opr_id   <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_y    <= 8'h00;
      rsp_cout <= 1'b0;
      done_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (grant_vld) begin
        opr_a  <= grant_id ? req1_a  : req0_a;
        opr_b  <= grant_id ? req1_b  : req0_b;
        opr_op <= grant_id ? req1_op : req0_op;
        opr_id <= grant_id;
      end
      if (state == S_EXEC) begin
        rsp_y    <= alu_y;
        rsp_cout <= alu_cout;
        rsp_id   <= opr_id;
      end
      if ((state == S_RESP) && rsp_ready) begin
        done_cnt <= done_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        // The pointer moves only here, so a lone requester is served
        // back-to-back.
        rr_ptr   <= ~rsp_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// The bench drives alu_share_arbiter with CNT_W=4. It checks the DUT against
// a transaction-level reference model. For each request, the model decides
// which requester should be granted in the current cycle. It computes the
// expected ALU result with plain arithmetic and queues it. It then expects
// that result on the response port two edges after acceptance. It also
// counts completed handshakes to predict done_cnt modulo 16.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic             v0, v1;
  logic             req0_ready, req1_ready;
  logic [7:0]       a0, b0, a1, b1;
  logic [2:0]       op0, op1;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
  logic [7:0]       rsp_y;
  logic [CNT_W-1:0] done_cnt;

  alu_share_arbiter #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (v0),
    .req0_ready (req0_ready),
    .req0_a     (a0),
    .req0_b     (b0),
    .req0_op    (op0),
    .req1_valid (v1),
    .req1_ready (req1_ready),
    .req1_a     (a1),
    .req1_b     (b1),
    .req1_op    (op1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_y      (rsp_y),
    .rsp_cout   (rsp_cout),
    .busy       (busy),
    .done_cnt   (done_cnt)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [9:0]  exp_q[$];     // {id, cout, y}
  logic        grant_q[$];   // observed grant order
  logic        chk_en = 1'b0;
  logic        m_busy = 1'b0;
  int          m_age = 0;
  logic        m_ptr = 1'b0;
  int          m_done = 0;
  logic        acc0 = 1'b0, acc1 = 1'b0;
  logic        r0e, r1e, rv_e;
  logic [9:0]  e_rsp;
  logic        rand_mode = 1'b0;
  logic        keep_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference ALU, returns {cout, y}
  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int ai, bi, r;
    ai = a;
    bi = b;
    case (op)
      3'd0: begin r = ai + bi; return {r > 255, r[7:0]}; end
      3'd1: begin r = (ai - bi + 256) % 256; return {ai < bi, r[7:0]}; end
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: begin r = 255 - ai; return {1'b0, r[7:0]}; end
      3'd6: begin r = (ai * 2) % 256; return {ai >= 128, r[7:0]}; end
      default: begin r = ai / 2; return {ai % 2 == 1, r[7:0]}; end
    endcase
  endfunction

  // ---------------- per-cycle checker (outputs sampled on negedge) ----------------
  always @(negedge clk) begin
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (chk_en && rst_n) begin
      if (m_busy) m_age++;
      r0e  = !m_busy && v0 && (!v1 || m_ptr == 1'b0);
      r1e  = !m_busy && v1 && (!v0 || m_ptr == 1'b1);
      rv_e = m_busy && (m_age >= 2);
      check("req0_ready", req0_ready, r0e);
      check("req1_ready", req1_ready, r1e);
      check("busy", busy, m_busy);
      check("rsp_valid", rsp_valid, rv_e);
      check("done_cnt", done_cnt, m_done % 16);
      if (rv_e) begin
        if (exp_q.size() == 0) check("exp_q_nonempty", 0, 1);
        else begin
          e_rsp = exp_q[0];
          check("rsp_id", rsp_id, e_rsp[9]);
          check("rsp_cout", rsp_cout, e_rsp[8]);
          check("rsp_y", rsp_y, e_rsp[7:0]);
        end
      end
      acc0 = v0 && req0_ready;
      acc1 = v1 && req1_ready;
      if (r0e) begin
        exp_q.push_back({1'b0, alu_ref(a0, b0, op0)});
        m_busy = 1'b1; m_age = 0;
      end else if (r1e) begin
        exp_q.push_back({1'b1, alu_ref(a1, b1, op1)});
        m_busy = 1'b1; m_age = 0;
      end
      if (acc0) grant_q.push_back(1'b0);
      if (acc1) grant_q.push_back(1'b1);
      if (rv_e && rsp_ready && exp_q.size() > 0) begin
        e_rsp = exp_q.pop_front();
        m_ptr = ~e_rsp[9];
        m_done++;
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic new_ops0();
    a0 = 8'($urandom_range(0, 255)); b0 = 8'($urandom_range(0, 255)); op0 = 3'($urandom_range(0, 7));
  endtask

  task automatic new_ops1();
    a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255)); op1 = 3'($urandom_range(0, 7));
  endtask

  // Advance one cycle. Operands are changed only after an acceptance or
  // while valid is low.
  task automatic tick();
    @(posedge clk);
    #1;
    if (acc0) begin
      v0 = rand_mode ? 1'($urandom_range(0, 1)) : keep_valid;
      new_ops0();
    end else if (rand_mode && !v0 && $urandom_range(0, 1) == 1) begin
      v0 = 1'b1;
      new_ops0();
    end
    if (acc1) begin
      v1 = rand_mode ? 1'($urandom_range(0, 1)) : keep_valid;
      new_ops1();
    end else if (rand_mode && !v1 && $urandom_range(0, 1) == 1) begin
      v1 = 1'b1;
      new_ops1();
    end
    if (rand_mode) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    grant_q.delete();
    m_busy = 1'b0; m_age = 0; m_ptr = 1'b0; m_done = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bit seen;
    rst_n = 1'b0;
    v0 = 1'b1; v1 = 1'b1;
    a0 = 8'h11; b0 = 8'h22; op0 = 3'd0;
    a1 = 8'h33; b1 = 8'h44; op1 = 3'd1;
    rsp_ready = 1'b1;

    // Reset values with both requesters valid
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_y", rsp_y, 0);
    check("rst_rsp_cout", rsp_cout, 0);
    check("rst_busy", busy, 0);
    check("rst_done_cnt", done_cnt, 0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("first_grant_req0", req0_ready, 1);

    // Abort in EXEC with an asynchronous reset pulse
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #2;
    check("abort_busy", busy, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (3) tick();
    check("abort_done_cnt", done_cnt, 0);

    // Single ADD F0 + 20 from req0
    v0 = 1'b1; a0 = 8'hF0; b0 = 8'h20; op0 = 3'b000;
    rsp_ready = 1'b1;
    keep_valid = 1'b0;
    @(negedge clk);
    check("add_req0_ready", req0_ready, 1);
    tick();
    @(negedge clk);
    check("add_ready_exec", req0_ready, 0);
    tick();
    @(negedge clk);
    check("add_rsp_valid", rsp_valid, 1);
    check("add_rsp_y", rsp_y, 8'h10);
    check("add_rsp_cout", rsp_cout, 1);
    check("add_rsp_id", rsp_id, 0);
    tick();
    @(negedge clk);
    check("add_done_cnt", done_cnt, 1);

    // Round-robin with both valids held high
    keep_valid = 1'b1;
    v0 = 1'b1; new_ops0();
    v1 = 1'b1; new_ops1();
    grant_q.delete();
    n = 0;
    while (grant_q.size() < 4 && n < 100) begin tick(); n++; end
    if (grant_q.size() < 4) check("rr_timeout", 0, 1);
    else for (int i = 0; i < 4; i++) check("rr_grant", grant_q[i], (i + 1) % 2);

    // Backpressure: rsp_ready low for 5 cycles in RESP
    rsp_ready = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      tick(); n++;
      seen = rsp_valid;
    end
    check("bp_reached_resp", seen, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_busy", busy, 1);
      check("bp_rsp_valid", rsp_valid, 1);
    end
    n = m_done;
    rsp_ready = 1'b1;
    tick();
    tick();
    check("bp_one_handshake", m_done, n + 1);

    // Randomized traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 400; i++) tick();

    // Drain, then check counter wrap
    rand_mode = 1'b0;
    keep_valid = 1'b0;
    tick();
    v0 = 1'b0; v1 = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while (m_busy && n < 20) begin tick(); n++; end
    check("drain_idle", m_busy, 0);
    @(negedge clk);
    check("ops_at_least_17", (m_done >= 17), 1);
    check("wrap_done_cnt", done_cnt, m_done % 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
